memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
//  Memory stage of the 5-stage RV64 pipeline: consumes the execute-stage result, performs
//  load/store over the single-outstanding data bus, aligns and extends load data, and
//  registers the result for writeback. Drives the memory-stage stall and the forwarding tap.
//  One request in flight; a request, once issued, is never abandoned.
// PARAMETERS
//  XLEN      64  data/address width
//  REGW      5   register index width
// PORTS
//  clk            in   1     clock, rising edge
//  reset          in   1     asynchronous, active-low (0 = reset)
//  in_valid       in   1     execute-stage slot holds an instruction
//  in_error       in   1     instruction already faulted upstream; no bus access
//  in_pc          in   64    instruction PC
//  in_load        in   1     load op
//  in_store       in   1     store op
//  in_size        in   2     0=B 1=H 2=W 3=D
//  in_unsigned    in   1     zero-extend load
//  in_addr        in   64    ALU result: effective address / ALU value
//  in_wdata       in   64    store data (rs2)
//  in_regwrite    in   1     writes rd
//  in_dst         in   5     rd index
//  flushm         in   1     squash instruction in this stage
//  stopm          out  1     stall execute (hold its output)
//  req_valid      out  1     bus request
//  req_write      out  1     1=store
//  req_addr       out  64    byte address
//  req_size       out  2     as in_size
//  req_strobe     out  8     byte enables (store)
//  req_data       out  64    lane-shifted store data
//  resp_ok        in   1     request complete (one-cycle pulse)
//  resp_data      in   64    aligned 8-byte word (load)
//  out_valid      out  1     writeback slot valid
//  out_pc         out  64
//  out_regwrite   out  1
//  out_dst        out  5
//  out_result     out  64    load value or ALU value
//  out_error      out  1     in_error | misalign
//  tran_dst       out  5     forwarding rd (0 = none)
//  tran_data      out  64    forwarding value
//  tran_busy      out  1     tran_dst is a load not yet complete
// BEHAVIOUR
//  - live = in_valid & !in_error; mem = live & (in_load|in_store);
//    misalign = addr low bits nonzero for size (H:[0], W:[1:0], D:[2:0]); mis-aligned -> no bus, out_error=1.
//  - FSM IDLE/BUSY/DRAIN. Reset: IDLE, req_* = 0, out_valid=0, all out_* = 0.
//  - IDLE: mem & !misalign & !flushm -> latch req_addr/size/write/strobe/data, go BUSY.
//    Request issued cycle after arrival; req_valid = (state!=IDLE).
//  - BUSY: req_* stable until resp_ok. resp_ok -> IDLE; result captured on same edge.
//    flushm & !resp_ok -> DRAIN. flushm & resp_ok -> IDLE, result discarded.
//  - DRAIN: req held; resp_ok -> IDLE; response discarded, out_valid=0.
//  - stopm = (mem & !misalign & !(state==BUSY & resp_ok)) | state==DRAIN.
//    Minimum load/store latency 2 cycles (arrival, issue+resp).
//  - req_strobe = ((1<<(1<<size))-1) << addr[2:0];
//    req_data = in_wdata << 8*addr[2:0]; upper strobe bits truncated to 8.
//  - load: v = resp_data >> 8*addr[2:0], take 8/16/32/64 bits, sign- or zero-extend.
//  - output register, each edge:
//    flushm -> out_valid=0; else stopm -> out_valid=0 (bubble);
//    else latch in_* with out_valid=in_valid, out_result = load ? v : in_addr.
//  - tran_dst = (live & in_regwrite & !misalign & !flushm) ? in_dst : 0;
//    tran_data = load ? v : in_addr; tran_busy = in_load & stopm.
//  - Stores have out_regwrite=0. rd=0 never forwarded.
//  - Reset mid-BUSY: immediate IDLE, req_valid drops asynchronously; bus reset jointly.
// TESTING
//  - ALU op in_addr=0x1234, regwrite, dst=5 -> stopm=0, next edge out_valid=1, out_result=0x1234.
//  - LB addr=0x...03, unsigned=0, resp_data=0x00000000_80000000 byte3=0x80 -> result 0xFFFF_FFFF_FFFF_FF80.
//  - SH addr=0x...06 wdata=0xBEEF -> req_strobe=0xC0, req_data=0xBEEF<<48, write=1.
//  - LW addr=0x...02 -> no req_valid, stopm=0, out_error=1.
//  - flushm in BUSY, resp_ok 3 cycles later -> DRAIN; req stable; stopm=1 until resp_ok; out_valid stays 0.
//  - reset low during BUSY -> req_valid=0 same cycle, state IDLE, out_valid=0.

Source files
------------

// File: rtl/memory_access_if.sv
// Single-outstanding data bus between the memory stage (master) and the data memory (slave).
// The request holds steady from issue until the one-cycle resp_ok pulse.
interface memory_access_if #(parameter int XLEN = 64);
  logic            req_valid;
  logic            req_write;
  logic [XLEN-1:0] req_addr;
  logic [1:0]      req_size;
  logic [7:0]      req_strobe;
  logic [XLEN-1:0] req_data;
  logic            resp_ok;
  logic [XLEN-1:0] resp_data;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_strobe, req_data,
    input  resp_ok, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_strobe, req_data,
    output resp_ok, resp_data
  );
endinterface

// File: rtl/memory_access.sv
// RV64 memory stage: issues loads/stores on the single-outstanding bus, aligns and extends
// load data, registers the writeback slot and drives the stall and forwarding tap.
module memory_access #(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            in_error,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_load,
  input  logic            in_store,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            in_regwrite,
  input  logic [REGW-1:0] in_dst,
  input  logic            flushm,
  output logic            stopm,
  memory_access_if.master bus,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic            out_regwrite,
  output logic [REGW-1:0] out_dst,
  output logic [XLEN-1:0] out_result,
  output logic            out_error,
  output logic [REGW-1:0] tran_dst,
  output logic [XLEN-1:0] tran_data,
  output logic            tran_busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t          state;
  logic            live;
  logic            mem;
  logic            misalign;
  logic [2:0]      offset;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] load_value;
  logic [7:0]      byte_mask;
  logic [15:0]     strobe_wide;
  logic [XLEN-1:0] result;

  assign live   = in_valid & ~in_error;
  assign mem    = live & (in_load | in_store);
  assign offset = in_addr[2:0];

  // NOTE: every signal driven from always_comb gets a default first, so no latch is inferred.
  always_comb begin
    misalign  = 1'b0;
    byte_mask = 8'hFF;
    case (in_size)
      2'd0: begin misalign = 1'b0;          byte_mask = 8'h01; end
      2'd1: begin misalign = offset[0];     byte_mask = 8'h03; end
      2'd2: begin misalign = |offset[1:0];  byte_mask = 8'h0F; end
      default: begin misalign = |offset;    byte_mask = 8'hFF; end
    endcase
    misalign = misalign & mem;
  end

  // Bytes pushed past lane 7 fall off, so a full-width strobe shifted up is clipped to 8 bits.
  assign strobe_wide = {8'h00, byte_mask} << offset;

  always_comb begin
    lane       = bus.resp_data >> {offset, 3'b000};
    load_value = lane;
    case (in_size)
      2'd0: load_value = {{(XLEN-8){~in_unsigned & lane[7]}},   lane[7:0]};
      2'd1: load_value = {{(XLEN-16){~in_unsigned & lane[15]}}, lane[15:0]};
      2'd2: load_value = {{(XLEN-32){~in_unsigned & lane[31]}}, lane[31:0]};
      default: load_value = lane;
    endcase
  end

  assign result    = in_load ? load_value : in_addr;
  assign stopm     = (mem & ~misalign & ~((state == BUSY) & bus.resp_ok)) | (state == DRAIN);
  assign tran_dst  = (live & in_regwrite & ~misalign & ~flushm) ? in_dst : '0;
  assign tran_data = result;
  assign tran_busy = in_load & stopm;

  // req_valid follows the state register directly, so reset drops it without waiting for a clock.
  assign bus.req_valid = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      bus.req_write  <= 1'b0;
      bus.req_addr   <= '0;
      bus.req_size   <= '0;
      bus.req_strobe <= '0;
      bus.req_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem & ~misalign & ~flushm) begin
            state          <= BUSY;
            bus.req_write  <= in_store;
            bus.req_addr   <= in_addr;
            bus.req_size   <= in_size;
            bus.req_strobe <= strobe_wide[7:0];
            bus.req_data   <= in_wdata << {offset, 3'b000};
          end
        end
        BUSY: begin
          if (bus.resp_ok)  state <= IDLE;
          else if (flushm)  state <= DRAIN;
        end
        DRAIN: begin
          // The bus cannot abandon a request, so a squashed access waits out its response.
          if (bus.resp_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_regwrite <= 1'b0;
      out_dst      <= '0;
      out_result   <= '0;
      out_error    <= 1'b0;
    end else if (flushm || stopm) begin
      out_valid <= 1'b0;
    end else begin
      out_valid    <= in_valid;
      out_pc       <= in_pc;
      out_regwrite <= in_regwrite & ~in_store;
      out_dst      <= in_dst;
      out_result   <= result;
      out_error    <= in_error | misalign;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed cases, flush/drain, reset mid-access and
// randomized back-to-back traffic against a transaction-level reference model.
module tb_memory_access;

  typedef struct {
    logic        valid;
    logic        error;
    logic        load;
    logic        store;
    logic        uns;
    logic        regwrite;
    logic [1:0]  size;
    logic [63:0] pc;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] resp;
    logic [4:0]  dst;
    int          lat;
  } op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_error, in_load, in_store, in_unsigned, in_regwrite, flushm;
  logic [63:0] in_pc, in_addr, in_wdata;
  logic [1:0]  in_size;
  logic [4:0]  in_dst;
  logic        stopm, out_valid, out_regwrite, out_error, tran_busy;
  logic [63:0] out_pc, out_result, tran_data;
  logic [4:0]  out_dst, tran_dst;

  int checks   = 0;
  int failures = 0;

  memory_access_if #(.XLEN(64)) bus ();

  memory_access #(.XLEN(64), .REGW(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_error(in_error), .in_pc(in_pc), .in_load(in_load),
    .in_store(in_store), .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_regwrite(in_regwrite), .in_dst(in_dst), .flushm(flushm),
    .stopm(stopm), .bus(bus),
    .out_valid(out_valid), .out_pc(out_pc), .out_regwrite(out_regwrite), .out_dst(out_dst),
    .out_result(out_result), .out_error(out_error),
    .tran_dst(tran_dst), .tran_data(tran_data), .tran_busy(tran_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: byte-level view of the bus lanes.
  function automatic logic [63:0] model_load(input logic [63:0] resp, input logic [63:0] addr,
                                             input logic [1:0] size, input logic uns);
    int off = int'(addr % 8);
    int n   = 1 << size;
    logic [63:0] r = '0;
    for (int j = 0; j < n; j++)
      if (off + j < 8) r[8*j +: 8] = resp[8*(off+j) +: 8];
    if (!uns && n < 8 && r[8*n-1])
      for (int j = n; j < 8; j++) r[8*j +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [7:0] model_strobe(input logic [63:0] addr, input logic [1:0] size);
    int off = int'(addr % 8);
    int n   = 1 << size;
    logic [7:0] s = '0;
    for (int i = 0; i < 8; i++) s[i] = (i >= off) && (i < off + n);
    return s;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] addr, input logic [63:0] wdata);
    int off = int'(addr % 8);
    logic [63:0] d = '0;
    for (int j = 0; j + off < 8; j++) d[8*(off+j) +: 8] = wdata[8*j +: 8];
    return d;
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_error = 0; in_load = 0; in_store = 0; in_unsigned = 0;
    in_regwrite = 0; flushm = 0; in_pc = '0; in_addr = '0; in_wdata = '0;
    in_size = '0; in_dst = '0; bus.resp_ok = 0; bus.resp_data = '0;
  endtask

  task automatic drive_op(input op_t op);
    in_valid = op.valid; in_error = op.error; in_load = op.load; in_store = op.store;
    in_unsigned = op.uns; in_regwrite = op.regwrite; in_size = op.size; in_pc = op.pc;
    in_addr = op.addr; in_wdata = op.wdata; in_dst = op.dst;
    flushm = 0; bus.resp_ok = 0; bus.resp_data = op.resp;
  endtask

  function automatic op_t make_op(input logic ld, input logic st, input logic [1:0] size,
                                  input logic [63:0] addr, input logic [63:0] wdata,
                                  input logic [63:0] resp, input logic [4:0] dst);
    op_t op;
    op.valid = 1; op.error = 0; op.load = ld; op.store = st; op.uns = 0;
    op.regwrite = ~st; op.size = size; op.pc = 64'h8000_0000 + {48'h0, 16'($urandom)};
    op.addr = addr; op.wdata = wdata; op.resp = resp; op.dst = dst; op.lat = 1;
    return op;
  endfunction

  // Runs one instruction through the stage, starting and ending with the FSM idle.
  task automatic run_op(input op_t op, input string tag);
    int          n    = 1 << op.size;
    logic        live = op.valid & ~op.error;
    logic        mem  = live & (op.load | op.store);
    logic        mis  = mem && (op.addr % n != 0);
    logic        acc  = mem & ~mis;
    logic [63:0] v    = model_load(op.resp, op.addr, op.size, op.uns);
    logic [63:0] tdat = op.load ? v : op.addr;
    logic [4:0]  tdst = (live & op.regwrite & ~mis) ? op.dst : 5'd0;

    @(negedge clk);
    drive_op(op);
    #1;
    checks++; if (stopm !== acc) begin failures++; $display("FAIL %s.stopm_arrive got=%0h exp=%0h", tag, stopm, acc); end
    checks++; if (tran_dst !== tdst) begin failures++; $display("FAIL %s.tran_dst got=%0d exp=%0d", tag, tran_dst, tdst); end
    checks++; if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL %s.req_early got=%0h exp=0", tag, bus.req_valid); end

    if (acc) begin
      checks++; if (tran_busy !== op.load) begin failures++; $display("FAIL %s.tran_busy got=%0h exp=%0h", tag, tran_busy, op.load); end
      @(posedge clk); #1;
      checks++; if (bus.req_valid !== 1'b1) begin failures++; $display("FAIL %s.req_valid got=%0h exp=1", tag, bus.req_valid); end
      checks++; if (bus.req_write !== op.store) begin failures++; $display("FAIL %s.req_write got=%0h exp=%0h", tag, bus.req_write, op.store); end
      checks++; if (bus.req_addr !== op.addr) begin failures++; $display("FAIL %s.req_addr got=%0h exp=%0h", tag, bus.req_addr, op.addr); end
      checks++; if (bus.req_size !== op.size) begin failures++; $display("FAIL %s.req_size got=%0h exp=%0h", tag, bus.req_size, op.size); end
      checks++; if (bus.req_strobe !== model_strobe(op.addr, op.size)) begin failures++; $display("FAIL %s.req_strobe got=%0h exp=%0h", tag, bus.req_strobe, model_strobe(op.addr, op.size)); end
      if (op.store) begin
        checks++; if (bus.req_data !== model_wdata(op.addr, op.wdata)) begin failures++; $display("FAIL %s.req_data got=%0h exp=%0h", tag, bus.req_data, model_wdata(op.addr, op.wdata)); end
      end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL %s.bubble got=%0h exp=0", tag, out_valid); end
      for (int c = 0; c < op.lat; c++) begin
        @(posedge clk); #1;
        checks++; if (stopm !== 1'b1) begin failures++; $display("FAIL %s.stopm_wait got=%0h exp=1", tag, stopm); end
        checks++; if (bus.req_valid !== 1'b1 || bus.req_addr !== op.addr) begin failures++; $display("FAIL %s.req_hold got=%0h/%0h exp=1/%0h", tag, bus.req_valid, bus.req_addr, op.addr); end
      end
      @(negedge clk);
      bus.resp_ok = 1;
      #1;
      checks++; if (stopm !== 1'b0) begin failures++; $display("FAIL %s.stopm_resp got=%0h exp=0", tag, stopm); end
      checks++; if (tran_data !== tdat) begin failures++; $display("FAIL %s.tran_data got=%0h exp=%0h", tag, tran_data, tdat); end
    end else begin
      checks++; if (tran_data !== tdat) begin failures++; $display("FAIL %s.tran_data got=%0h exp=%0h", tag, tran_data, tdat); end
    end

    @(posedge clk); #1;
    bus.resp_ok = 0;
    checks++; if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL %s.req_done got=%0h exp=0", tag, bus.req_valid); end
    checks++; if (out_valid !== op.valid) begin failures++; $display("FAIL %s.out_valid got=%0h exp=%0h", tag, out_valid, op.valid); end
    if (op.valid) begin
      checks++; if (out_result !== tdat) begin failures++; $display("FAIL %s.out_result got=%0h exp=%0h", tag, out_result, tdat); end
      checks++; if (out_error !== (op.error | mis)) begin failures++; $display("FAIL %s.out_error got=%0h exp=%0h", tag, out_error, op.error | mis); end
      checks++; if (out_pc !== op.pc || out_dst !== op.dst) begin failures++; $display("FAIL %s.out_pc_dst got=%0h/%0d exp=%0h/%0d", tag, out_pc, out_dst, op.pc, op.dst); end
      checks++; if (out_regwrite !== (op.regwrite & ~op.store)) begin failures++; $display("FAIL %s.out_regwrite got=%0h exp=%0h", tag, out_regwrite, op.regwrite & ~op.store); end
    end
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.req_valid !== 1'b0 || bus.req_strobe !== 8'h00 || bus.req_addr !== 64'h0) begin failures++; $display("FAIL reset.req got=%0h/%0h/%0h exp=0/0/0", bus.req_valid, bus.req_strobe, bus.req_addr); end
    checks++; if (out_valid !== 1'b0 || out_result !== 64'h0 || out_error !== 1'b0) begin failures++; $display("FAIL reset.out got=%0h/%0h/%0h exp=0/0/0", out_valid, out_result, out_error); end
    checks++; if (stopm !== 1'b0 || tran_dst !== 5'd0) begin failures++; $display("FAIL reset.stall_tap got=%0h/%0d exp=0/0", stopm, tran_dst); end
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_directed();
    op_t op;
    op = make_op(0, 0, 2'd3, 64'h1234, '0, '0, 5'd5);
    run_op(op, "alu");
    op = make_op(1, 0, 2'd0, 64'h0000_0000_1000_0003, '0, 64'h0000_0000_8000_0000, 5'd7);
    op.lat = 2;
    run_op(op, "lb_sign");
    checks++; if (out_result !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("FAIL lb_value got=%0h exp=ffffffffffffff80", out_result); end
    op = make_op(0, 1, 2'd1, 64'h0000_0000_2000_0006, 64'hBEEF, '0, 5'd0);
    op.lat = 0;
    run_op(op, "sh_lane");
    op = make_op(1, 0, 2'd2, 64'h0000_0000_3000_0002, '0, 64'h1122_3344_5566_7788, 5'd9);
    run_op(op, "lw_misalign");
    checks++; if (out_error !== 1'b1) begin failures++; $display("FAIL lw_misalign.error got=%0h exp=1", out_error); end
    op = make_op(1, 0, 2'd1, 64'h0000_0000_4000_0006, '0, 64'h8765_0000_0000_0000, 5'd3);
    op.uns = 1;
    run_op(op, "lhu_top");
  endtask

  task automatic test_flush();
    op_t op;
    op = make_op(1, 0, 2'd3, 64'h2000, '0, 64'hDEAD_BEEF_0000_0001, 5'd4);
    @(negedge clk); drive_op(op);
    @(posedge clk); #1;
    checks++; if (bus.req_valid !== 1'b1) begin failures++; $display("FAIL flush.issue got=%0h exp=1", bus.req_valid); end
    @(negedge clk); flushm = 1; #1;
    checks++; if (stopm !== 1'b1 || tran_dst !== 5'd0) begin failures++; $display("FAIL flush.busy got=%0h/%0d exp=1/0", stopm, tran_dst); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush.out got=%0h exp=0", out_valid); end
    @(negedge clk); flushm = 0; in_valid = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (stopm !== 1'b1) begin failures++; $display("FAIL flush.drain_stop got=%0h exp=1", stopm); end
      checks++; if (bus.req_valid !== 1'b1 || bus.req_addr !== 64'h2000) begin failures++; $display("FAIL flush.drain_req got=%0h/%0h exp=1/2000", bus.req_valid, bus.req_addr); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush.drain_out got=%0h exp=0", out_valid); end
      @(negedge clk);
    end
    bus.resp_ok = 1; #1;
    checks++; if (stopm !== 1'b1) begin failures++; $display("FAIL flush.drain_resp got=%0h exp=1", stopm); end
    @(posedge clk); #1;
    bus.resp_ok = 0;
    checks++; if (bus.req_valid !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush.drained got=%0h/%0h exp=0/0", bus.req_valid, out_valid); end
    @(negedge clk); #1;
    checks++; if (stopm !== 1'b0) begin failures++; $display("FAIL flush.released got=%0h exp=0", stopm); end

    op = make_op(0, 1, 2'd2, 64'h2004, 64'h0BAD_F00D, '0, 5'd0);
    drive_op(op);
    @(posedge clk); #1;
    @(negedge clk); flushm = 1; bus.resp_ok = 1; #1;
    checks++; if (stopm !== 1'b0) begin failures++; $display("FAIL flush_resp.stopm got=%0h exp=0", stopm); end
    @(posedge clk); #1;
    idle_inputs();
    checks++; if (bus.req_valid !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_resp.idle got=%0h/%0h exp=0/0", bus.req_valid, out_valid); end
  endtask

  task automatic test_reset_busy();
    op_t op;
    op = make_op(0, 0, 2'd3, 64'h55, '0, '0, 5'd2);
    run_op(op, "pre_reset");
    op = make_op(1, 0, 2'd2, 64'h3000, '0, 64'h1, 5'd6);
    @(negedge clk); drive_op(op);
    @(posedge clk); #1;
    checks++; if (bus.req_valid !== 1'b1) begin failures++; $display("FAIL rst_busy.issue got=%0h exp=1", bus.req_valid); end
    @(negedge clk); #2;
    reset = 0; #1;
    checks++; if (bus.req_valid !== 1'b0 || bus.req_addr !== 64'h0) begin failures++; $display("FAIL rst_busy.req got=%0h/%0h exp=0/0", bus.req_valid, bus.req_addr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_busy.out got=%0h exp=0", out_valid); end
    idle_inputs();
    @(negedge clk);
    reset = 1;
    op = make_op(0, 0, 2'd3, 64'hABCD, '0, '0, 5'd8);
    run_op(op, "post_reset");
  endtask

  task automatic test_back_to_back();
    op_t op;
    for (int i = 0; i < 300; i++) begin
      int kind = int'($urandom_range(0, 2));
      op.valid    = ($urandom_range(0, 9) != 0);
      op.error    = ($urandom_range(0, 9) == 0);
      op.load     = (kind == 1);
      op.store    = (kind == 2);
      op.uns      = 1'($urandom);
      op.regwrite = 1'($urandom);
      op.size     = 2'($urandom);
      op.pc       = {32'($urandom), 32'($urandom)};
      op.addr     = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) != 0) op.addr = op.addr & ~64'((1 << op.size) - 1);
      op.wdata    = {32'($urandom), 32'($urandom)};
      op.resp     = {32'($urandom), 32'($urandom)};
      op.dst      = 5'($urandom);
      op.lat      = int'($urandom_range(0, 3));
      run_op(op, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_reset_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
